// File: rtl/rgb_pwm_driver.sv
// RGB LED PWM driver: captures colour/duty at period boundaries and drives three glitch-free outputs.
// Optional macro RGB_FADE_EN adds a per-period fade-in of the on-time.
module rgb_pwm_driver #(
   parameter int PWM_BITS  = 8,
   parameter int FADE_STEP = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [2:0]          colour,
   input  logic [PWM_BITS-1:0] duty,
   output logic [2:0]          rgb,
   output logic                period_tick,
   output logic                colour_err
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state, state_n;
   logic [PWM_BITS-1:0] cnt, cnt_n;
   logic [2:0]          col_q, col_n, col_in;
   logic [PWM_BITS-1:0] duty_q, duty_n;
   logic [PWM_BITS-1:0] eff_n;
   logic                err_n, load;
   logic [2:0]          rgb_n;
   logic                tick_n;

`ifdef RGB_FADE_EN
   localparam int STEP_C = (FADE_STEP > (1 << PWM_BITS)) ? (1 << PWM_BITS) : FADE_STEP;
   localparam logic [PWM_BITS:0] STEP = STEP_C[PWM_BITS:0];

   logic [PWM_BITS-1:0] fade_q, fade_n;

   // One extra bit on the sum so a large step saturates at the limit instead of wrapping.
   function automatic logic [PWM_BITS-1:0] fade_sat(input logic [PWM_BITS-1:0] base,
                                                    input logic [PWM_BITS-1:0] lim);
      logic [PWM_BITS:0] sum;
      sum = {1'b0, base} + STEP;
      return (sum > {1'b0, lim}) ? lim : sum[PWM_BITS-1:0];
   endfunction
`else
   logic unused_fade;
   assign unused_fade = ^FADE_STEP;
`endif

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      load    = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (enable) begin
               state_n = RUN;
               load    = 1'b1;
            end
         end
         RUN: begin
            if (!enable) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
               load  = (cnt == '1);
            end
         end
         default: state_n = IDLE;
      endcase

      col_in = (colour == 3'd7) ? 3'd0 : colour;
      col_n  = load ? col_in : col_q;
      duty_n = load ? duty : duty_q;
      err_n  = colour_err | (load && colour == 3'd7);

`ifdef RGB_FADE_EN
      fade_n = fade_q;
      if (load) begin
         if (state == IDLE || col_n != col_q)
            fade_n = fade_sat('0, duty);
         else
            fade_n = fade_sat(fade_q, duty);
      end
      eff_n = fade_n;
`else
      eff_n = duty_n;
`endif

      // Outputs are computed from next-cycle register values so they can themselves be flops.
      rgb_n  = (state_n == RUN && cnt_n < eff_n) ? col_n : 3'b000;
      tick_n = (state_n == RUN) && (cnt_n == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         col_q       <= '0;
         duty_q      <= '0;
         colour_err  <= 1'b0;
         rgb         <= 3'b000;
         period_tick <= 1'b0;
`ifdef RGB_FADE_EN
         fade_q      <= '0;
`endif
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         col_q       <= col_n;
         duty_q      <= duty_n;
         colour_err  <= err_n;
         rgb         <= rgb_n;
         period_tick <= tick_n;
`ifdef RGB_FADE_EN
         fade_q      <= fade_n;
`endif
      end
   end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver with PWM_BITS=4; fade sequence exercised when RGB_FADE_EN is defined.
module tb_rgb_pwm_driver;

   logic       clk = 1'b0;
   logic       rst, enable;
   logic [2:0] colour;
   logic [3:0] duty;
   logic [2:0] rgb;
   logic       period_tick, colour_err;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   always #5 clk = ~clk;

   // FADE_STEP=16 exceeds every 4-bit duty, so this instance behaves identically with or without fade.
   rgb_pwm_driver #(.PWM_BITS(4), .FADE_STEP(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .colour(colour), .duty(duty),
      .rgb(rgb), .period_tick(period_tick), .colour_err(colour_err)
   );

`ifdef RGB_FADE_EN
   logic       f_rst, f_en;
   logic [2:0] f_col;
   logic [3:0] f_duty;
   logic [2:0] f_rgb;
   logic       f_tick, f_err;

   rgb_pwm_driver #(.PWM_BITS(4), .FADE_STEP(2)) dut_fade (
      .clk(clk), .rst(f_rst), .enable(f_en), .colour(f_col), .duty(f_duty),
      .rgb(f_rgb), .period_tick(f_tick), .colour_err(f_err)
   );
`endif

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full 16-cycle period starting at cnt=0; optional input change after checking cycle chg_at.
   task automatic period(input logic [2:0] col, input int on, input int chg_at,
                         input logic [2:0] ncol, input logic [3:0] nduty);
      for (int c = 0; c < 16; c++) begin
         chk($sformatf("rgb c%0d", c), {5'd0, rgb}, (c < on) ? {5'd0, col} : 8'd0);
         chk($sformatf("tick c%0d", c), {7'd0, period_tick}, (c == 0) ? 8'd1 : 8'd0);
         if (c == chg_at) begin
            colour = ncol;
            duty   = nduty;
         end
         tick();
      end
   endtask

`ifdef RGB_FADE_EN
   task automatic fperiod(input logic [2:0] col, input int on, input int chg_at, input logic [2:0] ncol);
      for (int c = 0; c < 16; c++) begin
         chk($sformatf("fade rgb c%0d", c), {5'd0, f_rgb}, (c < on) ? {5'd0, col} : 8'd0);
         if (c == chg_at) f_col = ncol;
         tick();
      end
   endtask
`endif

   initial begin
      rst = 1'b1; enable = 1'b1; colour = 3'd5; duty = 4'd4;
`ifdef RGB_FADE_EN
      f_rst = 1'b1; f_en = 1'b0; f_col = 3'd0; f_duty = 4'd0;
`endif
      @(negedge clk);
      tick();
      tick();
      chk("rst rgb", {5'd0, rgb}, 8'd0);
      chk("rst tick", {7'd0, period_tick}, 8'd0);
      chk("rst err", {7'd0, colour_err}, 8'd0);

      // Release reset; first RUN cycle is cnt=0 with the load-from-IDLE values.
      rst = 1'b0; colour = 3'd1; duty = 4'd4;
`ifdef RGB_FADE_EN
      f_rst = 1'b0;
`endif
      tick();
      period(3'b001, 4, -1, 3'd1, 4'd4);
      period(3'b001, 4, 5, 3'd6, 4'd8);
      period(3'b110, 8, 3, 3'd6, 4'd0);
      period(3'b110, 0, 7, 3'd3, 4'd15);
      period(3'b011, 15, 9, 3'd7, 4'd15);
      chk("err set", {7'd0, colour_err}, 8'd1);
      period(3'b000, 15, 4, 3'd2, 4'd5);
      chk("err sticky", {7'd0, colour_err}, 8'd1);

      // Drop enable at cnt=2.
      chk("pre-drop rgb c0", {5'd0, rgb}, 8'h02);
      chk("pre-drop tick c0", {7'd0, period_tick}, 8'd1);
      tick();
      chk("pre-drop rgb c1", {5'd0, rgb}, 8'h02);
      tick();
      chk("pre-drop rgb c2", {5'd0, rgb}, 8'h02);
      enable = 1'b0;
      tick();
      chk("idle rgb", {5'd0, rgb}, 8'd0);
      chk("idle tick", {7'd0, period_tick}, 8'd0);
      tick();
      chk("idle rgb 2", {5'd0, rgb}, 8'd0);
      chk("idle tick 2", {7'd0, period_tick}, 8'd0);
      chk("idle err", {7'd0, colour_err}, 8'd1);

      enable = 1'b1; colour = 3'd4; duty = 4'd3;
      tick();
      period(3'b100, 3, 5, 3'd0, 4'd8);
      period(3'b000, 8, -1, 3'd0, 4'd8);

      rst = 1'b1;
      tick();
      chk("rst2 err", {7'd0, colour_err}, 8'd0);
      chk("rst2 rgb", {5'd0, rgb}, 8'd0);
      chk("rst2 tick", {7'd0, period_tick}, 8'd0);
      rst = 1'b0; enable = 1'b0;

`ifdef RGB_FADE_EN
      f_en = 1'b1; f_col = 3'd1; f_duty = 4'd6;
      tick();
      chk("fade tick", {7'd0, f_tick}, 8'd1);
      fperiod(3'b001, 2, -1, 3'd1);
      fperiod(3'b001, 4, -1, 3'd1);
      fperiod(3'b001, 6, -1, 3'd1);
      fperiod(3'b001, 6, 3, 3'd2);
      fperiod(3'b010, 2, -1, 3'd2);
      fperiod(3'b010, 4, -1, 3'd2);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
